// File: rtl/pe_context_sequencer.sv
// Context sequencer for a PE: loads a program of context words into a small
// memory, then replays it to the PE configuration port for loop_count passes.
module pe_context_sequencer #(
  parameter int ContextWidth = 22,
  parameter int Depth        = 16,
  parameter int AddrWidth    = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cfg_in_valid,
  output logic                    cfg_in_ready,
  input  logic [ContextWidth-1:0] cfg_in_data,
  input  logic                    cfg_in_last,
  input  logic                    start,
  input  logic [15:0]             loop_count,
  output logic [ContextWidth-1:0] configuration,
  output logic                    busy,
  output logic                    done,
  output logic                    overflow
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DONE
  } state_e;

  localparam logic [AddrWidth-1:0] LastAddr = AddrWidth'(Depth - 1);

  state_e                  state_q, state_d;
  logic [AddrWidth-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AddrWidth-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AddrWidth:0]      num_ctx_q, num_ctx_d;
  logic [15:0]             pass_q, pass_d;
  logic [ContextWidth-1:0] cfg_q, cfg_d;
  logic                    ovf_q, ovf_d;

  logic [ContextWidth-1:0] mem [Depth];

  logic                    beat;
  logic                    mem_we;
  logic                    fetch;
  logic [AddrWidth-1:0]    load_addr;
  logic [AddrWidth-1:0]    last_rd;

  assign cfg_in_ready = (state_q == S_IDLE) || (state_q == S_LOAD);
  assign beat         = cfg_in_valid && cfg_in_ready;
  // A beat arriving in IDLE always starts a fresh program at entry 0.
  assign load_addr    = (state_q == S_IDLE) ? '0 : wr_ptr_q;
  assign last_rd      = AddrWidth'(num_ctx_q - (AddrWidth + 1)'(1));

  assign configuration = cfg_q;
  assign busy          = (state_q == S_LOAD) || (state_q == S_RUN);
  assign done          = (state_q == S_DONE);
  assign overflow      = ovf_q;

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case leaves it unassigned (no latch).
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    num_ctx_d = num_ctx_q;
    pass_d    = pass_q;
    ovf_d     = ovf_q;
    cfg_d     = cfg_q;
    mem_we    = 1'b0;
    fetch     = 1'b0;

    case (state_q)
      S_IDLE, S_LOAD: begin
        if (beat) begin
          mem_we = 1'b1;
          if (state_q == S_IDLE) ovf_d = 1'b0;
          if (cfg_in_last) begin
            num_ctx_d = {1'b0, load_addr} + (AddrWidth + 1)'(1);
            wr_ptr_d  = '0;
            state_d   = S_IDLE;
          end else if (load_addr == LastAddr) begin
            num_ctx_d = (AddrWidth + 1)'(Depth);
            ovf_d     = 1'b1;
            wr_ptr_d  = '0;
            state_d   = S_IDLE;
          end else begin
            wr_ptr_d = load_addr + AddrWidth'(1);
            state_d  = S_LOAD;
          end
        end else if (state_q == S_IDLE && start &&
                     num_ctx_q != '0 && loop_count != 16'd0) begin
          state_d  = S_RUN;
          rd_ptr_d = '0;
          pass_d   = loop_count;
          fetch    = 1'b1;
        end
      end
      S_RUN: begin
        if (rd_ptr_q == last_rd) begin
          if (pass_q == 16'd1) begin
            pass_d  = 16'd0;
            state_d = S_DONE;
          end else begin
            rd_ptr_d = '0;
            pass_d   = pass_q - 16'd1;
            fetch    = 1'b1;
          end
        end else begin
          rd_ptr_d = rd_ptr_q + AddrWidth'(1);
          fetch    = 1'b1;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // configuration is only refreshed when a new entry is due; otherwise it holds.
    if (fetch) cfg_d = mem[rd_ptr_d];
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      num_ctx_q <= '0;
      pass_q    <= 16'd0;
      cfg_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      num_ctx_q <= num_ctx_d;
      pass_q    <= pass_d;
      cfg_q     <= cfg_d;
      ovf_q     <= ovf_d;
    end
  end

  // NOTE: the memory has no reset; num_ctx=0 after reset keeps stale contents from ever being played.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) mem[load_addr] <= cfg_in_data;
  end

endmodule

// File: tb/tb_pe_context_sequencer.sv
// Directed bench for pe_context_sequencer: a reference model of the context
// memory feeds a scoreboard queue that is drained while the DUT plays.
module tb_pe_context_sequencer;

  localparam int CW = 22;
  localparam int DP = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_in_valid;
  logic          cfg_in_ready;
  logic [CW-1:0] cfg_in_data;
  logic          cfg_in_last;
  logic          start;
  logic [15:0]   loop_count;
  logic [CW-1:0] configuration;
  logic          busy;
  logic          done;
  logic          overflow;

  int checks   = 0;
  int failures = 0;

  logic [CW-1:0] m_mem [DP];
  int            m_num     = 0;
  int            m_wp      = 0;
  bit            m_loading = 1'b0;
  bit            m_ovf     = 1'b0;
  logic [CW-1:0] words [32];
  logic [CW-1:0] exp_q [$];
  logic [CW-1:0] last_cfg;

  pe_context_sequencer #(.ContextWidth(CW), .Depth(DP), .AddrWidth(AW)) dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_in_valid  (cfg_in_valid),
    .cfg_in_ready  (cfg_in_ready),
    .cfg_in_data   (cfg_in_data),
    .cfg_in_last   (cfg_in_last),
    .start         (start),
    .loop_count    (loop_count),
    .configuration (configuration),
    .busy          (busy),
    .done          (done),
    .overflow      (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Streams n words from words[]; last is flagged on the final word if requested.
  task automatic load(input int n, input bit last_on_final);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      cfg_in_valid = 1'b1;
      cfg_in_data  = words[i];
      cfg_in_last  = last_on_final && (i == n - 1);
      @(negedge clk);
      check("load_ready", 32'(cfg_in_ready), 32'd1);
      if (!m_loading) begin
        m_wp  = 0;
        m_ovf = 1'b0;
      end
      m_mem[m_wp] = words[i];
      if (cfg_in_last) begin
        m_num = m_wp + 1;  m_loading = 1'b0;
      end else if (m_wp == DP - 1) begin
        m_num = DP;  m_ovf = 1'b1;  m_loading = 1'b0;
      end else begin
        m_wp++;  m_loading = 1'b1;
      end
    end
    @(posedge clk); #1;
    cfg_in_valid = 1'b0;
    cfg_in_last  = 1'b0;
    @(negedge clk);
    check("load_overflow", 32'(overflow), 32'(m_ovf));
    check("load_busy", 32'(busy), 32'(m_loading));
  endtask

  task automatic run(input int lc, input bit hold_valid);
    for (int p = 0; p < lc; p++)
      for (int e = 0; e < m_num; e++) exp_q.push_back(m_mem[e]);
    last_cfg = m_mem[m_num - 1];
    @(posedge clk); #1;
    start      = 1'b1;
    loop_count = 16'(lc);
    @(posedge clk); #1;
    start = 1'b0;
    if (hold_valid) begin
      cfg_in_valid = 1'b1;
      cfg_in_data  = 22'h155555;
      cfg_in_last  = 1'b0;
    end
    for (int i = 0; i < lc * m_num; i++) begin
      @(negedge clk);
      check("run_cfg", 32'(configuration), 32'(exp_q.pop_front()));
      check("run_busy", 32'(busy), 32'd1);
      check("run_done", 32'(done), 32'd0);
      if (hold_valid) check("run_ready", 32'(cfg_in_ready), 32'd0);
      @(posedge clk); #1;
    end
    cfg_in_valid = 1'b0;
    @(negedge clk);
    check("done_pulse", 32'(done), 32'd1);
    check("done_busy", 32'(busy), 32'd0);
    check("done_cfg_hold", 32'(configuration), 32'(last_cfg));
    @(posedge clk); #1;
    @(negedge clk);
    check("post_done", 32'(done), 32'd0);
    check("post_busy", 32'(busy), 32'd0);
    check("post_cfg_hold", 32'(configuration), 32'(last_cfg));
    check("queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // start that must be ignored: nothing may move for a few cycles.
  task automatic start_ignored(input int lc, input logic [CW-1:0] exp_cfg);
    @(posedge clk); #1;
    start      = 1'b1;
    loop_count = 16'(lc);
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("ign_busy", 32'(busy), 32'd0);
      check("ign_done", 32'(done), 32'd0);
      check("ign_cfg", 32'(configuration), 32'(exp_cfg));
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst          = 1'b1;
    cfg_in_valid = 1'b0;
    cfg_in_data  = '0;
    cfg_in_last  = 1'b0;
    start        = 1'b0;
    loop_count   = 16'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_cfg", 32'(configuration), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_ready", 32'(cfg_in_ready), 32'd1);

    // No program loaded yet.
    start_ignored(5, '0);

    // Three-word program, two passes.
    words[0] = 22'h000A1; words[1] = 22'h000B2; words[2] = 22'h000C3;
    load(3, 1'b1);
    run(2, 1'b0);

    // loop_count of zero is ignored; configuration keeps the last word.
    start_ignored(0, 22'h000C3);

    // Replay without reload while cfg_in_valid is held high.
    run(2, 1'b1);

    // Overflow: 16 words without last become a full program.
    for (int i = 0; i < DP; i++) words[i] = 22'(32'h100 + i);
    load(DP, 1'b0);
    check("ovf_num_ready", 32'(cfg_in_ready), 32'd1);
    run(1, 1'b0);
    words[0] = 22'h002AA;
    load(1, 1'b0);
    check("ovf_cleared", 32'(overflow), 32'd0);
    words[0] = 22'h002BB;
    m_loading = 1'b1;
    load(1, 1'b1);
    run(2, 1'b0);

    // Single-word program.
    words[0] = 22'h3FFFFF;
    load(1, 1'b1);
    run(3, 1'b0);

    // Reset in the middle of a run.
    words[0] = 22'h000A1; words[1] = 22'h000B2; words[2] = 22'h000C3;
    load(3, 1'b1);
    @(posedge clk); #1;
    start      = 1'b1;
    loop_count = 16'd4;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("abort_first", 32'(configuration), 32'h000A1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_cfg", 32'(configuration), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("abort_no_done", 32'(done), 32'd0);
    end
    m_num = 0; m_loading = 1'b0; m_ovf = 1'b0;
    start_ignored(5, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
